// File: rtl/ahb_apb_bridge.sv
// AHB-Lite slave to APB3 master bridge.
// Each AHB transfer becomes one APB SETUP/ACCESS pair. Only one transfer is
// in flight at a time. An optional watchdog turns a stuck PREADY into an
// AHB ERROR response.
//
// Handshake: on the AHB side, an address phase is taken only when
// HSEL & HREADY & HTRANS[1]. The bridge holds HREADYOUT low until it can
// return the data phase. On the APB side, PSEL rises in SETUP and PENABLE
// rises in ACCESS. The access completes on the first ACCESS cycle with
// PREADY=1, and PSLVERR is looked at only in that cycle.
module ahb_apb_bridge #(
    parameter int NSLV    = 16,
    parameter int SEL_LSB = 12,
    parameter int TIMEOUT = 256
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [31:0]     HWDATA,
    input  logic            HREADY,
    output logic            HREADYOUT,
    output logic            HRESP,
    output logic [31:0]     HRDATA,
    output logic [NSLV-1:0] PSEL,
    output logic            PENABLE,
    output logic [31:0]     PADDR,
    output logic            PWRITE,
    output logic [31:0]     PWDATA,
    input  logic [31:0]     PRDATA,
    input  logic            PREADY,
    input  logic            PSLVERR,
    output logic [2:0]      dbg_state
);

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WD_LIMIT = WW'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic            req;
    logic [IW-1:0]   idx;
    logic [NSLV-1:0] sel_onehot;
    logic [WW-1:0]   wdog;
    logic [WW-1:0]   wdog_inc;
    logic            wdog_expired;
    logic            unused_inputs;

    // Transfer size is irrelevant because every access is a full word.
    // SEQ and NONSEQ are treated alike, so HTRANS[0] is not needed.
    assign unused_inputs = ^{HSIZE, HTRANS[0]};

    assign req        = HSEL & HREADY & HTRANS[1];
    assign idx        = PADDR[SEL_LSB +: IW];
    assign sel_onehot = {{(NSLV-1){1'b0}}, 1'b1} << idx;
    assign dbg_state  = state;

    // The watchdog value includes the current ACCESS cycle.
    // It saturates instead of wrapping.
    assign wdog_inc     = (&wdog) ? wdog : wdog + 1'b1;
    assign wdog_expired = (TIMEOUT != 0) && (wdog_inc == WD_LIMIT);

    // State register. Asynchronous reset returns to IDLE, so PSEL/PENABLE drop at once.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= ST_IDLE;
        else          state <= state_nx;
    end

    // Next-state logic. DONE accepts a new request directly for back-to-back traffic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (req) state_nx = HWRITE ? ST_WDATA : ST_SETUP;
                else     state_nx = ST_IDLE;
            end
            ST_WDATA:  state_nx = ST_SETUP;
            ST_SETUP:  state_nx = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY)            state_nx = PSLVERR ? ST_ERR1 : ST_DONE;
                else if (wdog_expired) state_nx = ST_ERR1;
            end
            ST_ERR1:   state_nx = ST_ERR2;
            ST_ERR2:   state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Outputs decoded from state. The two-cycle ERROR response is ERR1 then ERR2.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        PSEL      = '0;
        PENABLE   = 1'b0;
        case (state)
            ST_WDATA:  HREADYOUT = 1'b0;
            ST_SETUP: begin
                HREADYOUT = 1'b0;
                PSEL      = sel_onehot;
            end
            ST_ACCESS: begin
                HREADYOUT = 1'b0;
                PSEL      = sel_onehot;
                PENABLE   = 1'b1;
            end
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            ST_ERR2:   HRESP = 1'b1;
            default: ;
        endcase
    end

    // Datapath registers.
    // Address and direction are captured on an accepted request.
    // Write data is captured in the data phase.
    // Read data is captured on a good completion.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            HRDATA <= '0;
            wdog   <= '0;
        end else begin
            if ((state == ST_IDLE || state == ST_DONE) && req) begin
                PADDR  <= HADDR;
                PWRITE <= HWRITE;
            end
            if (state == ST_WDATA) PWDATA <= HWDATA;
            if (state_nx == ST_SETUP)     wdog <= '0;
            else if (state == ST_ACCESS)  wdog <= wdog_inc;
            if (state == ST_ACCESS && PREADY && !PSLVERR && !PWRITE) HRDATA <= PRDATA;
        end
    end

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge.
// One instance uses the default watchdog and a second uses TIMEOUT=4.
// A pipelined AHB driver issues transfers, and expected read data is queued
// when each read address phase is driven.
module tb_ahb_apb_bridge;

  // ---------------- clock / reset ----------------
  logic HCLK = 1'b0;
  always #5 HCLK = ~HCLK;
  logic HRESETn;

  // ---------------- shared stimulus ----------------
  logic        hsel, hsel_wd, hwrite, pslverr;
  logic [31:0] haddr, hwdata, prdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        pready;

  // ---------------- DUT outputs ----------------
  logic        a_hreadyout, a_hresp, a_penable, a_pwrite;
  logic [31:0] a_hrdata, a_paddr, a_pwdata;
  logic [15:0] a_psel;
  logic [2:0]  a_state;
  logic        b_hreadyout, b_hresp, b_penable, b_pwrite;
  logic [31:0] b_hrdata, b_paddr, b_pwdata;
  logic [15:0] b_psel;
  logic [2:0]  b_state;

  ahb_apb_bridge dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(a_hreadyout),
    .HREADYOUT(a_hreadyout), .HRESP(a_hresp), .HRDATA(a_hrdata), .PSEL(a_psel),
    .PENABLE(a_penable), .PADDR(a_paddr), .PWRITE(a_pwrite), .PWDATA(a_pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .dbg_state(a_state)
  );

  ahb_apb_bridge #(.TIMEOUT(4)) dut_wd (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(hsel_wd), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(b_hreadyout),
    .HREADYOUT(b_hreadyout), .HRESP(b_hresp), .HRDATA(b_hrdata), .PSEL(b_psel),
    .PENABLE(b_penable), .PADDR(b_paddr), .PWRITE(b_pwrite), .PWDATA(b_pwdata),
    .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr), .dbg_state(b_state)
  );

  // Monitored view: whichever instance the current step targets.
  logic        use_wd;
  logic        mo_hreadyout, mo_hresp, mo_penable, mo_pwrite;
  logic [31:0] mo_hrdata, mo_paddr, mo_pwdata;
  logic [15:0] mo_psel;
  logic [2:0]  mo_state;
  assign mo_hreadyout = use_wd ? b_hreadyout : a_hreadyout;
  assign mo_hresp     = use_wd ? b_hresp     : a_hresp;
  assign mo_hrdata    = use_wd ? b_hrdata    : a_hrdata;
  assign mo_psel      = use_wd ? b_psel      : a_psel;
  assign mo_penable   = use_wd ? b_penable   : a_penable;
  assign mo_paddr     = use_wd ? b_paddr     : a_paddr;
  assign mo_pwrite    = use_wd ? b_pwrite    : a_pwrite;
  assign mo_pwdata    = use_wd ? b_pwdata    : a_pwdata;
  assign mo_state     = use_wd ? b_state     : a_state;

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rd[2];
  logic        tr_write[4];
  logic [31:0] tr_addr[4];
  logic [31:0] tr_data[4];
  int          tr_stall[4];
  logic        tr_resp[4];
  logic        tr_apb[4];
  int          cur = 0;
  logic        err1_resp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- APB slave model ----------------
  // PREADY goes high once wait_n ACCESS cycles have passed.
  int wait_n = 0;
  int acc_cnt = 0;
  assign pready = (acc_cnt >= wait_n);
  assign prdata = tr_data[cur];
  always @(posedge HCLK) begin
    if (mo_penable && !pready) acc_cnt <= acc_cnt + 1;
    else if (!mo_penable)      acc_cnt <= 0;
  end

  // ---------------- APB monitor ----------------
  // Checks one-hot PSEL and that PENABLE never appears without PSEL.
  // Checks that address, direction and write data hold from SETUP to completion.
  logic [31:0] su_addr, su_wdata, ap_addr, ap_wdata;
  logic        su_write, ap_write;
  logic [15:0] ap_psel;
  always @(negedge HCLK) begin
    if (HRESETn && (mo_psel != 16'h0 || mo_penable)) begin
      check("psel_onehot", {31'b0, $onehot(mo_psel)}, 32'd1);
      if (!mo_penable) begin
        su_addr  = mo_paddr;
        su_wdata = mo_pwdata;
        su_write = mo_pwrite;
      end else begin
        check("paddr_stable", mo_paddr, su_addr);
        check("pwrite_stable", {31'b0, mo_pwrite}, {31'b0, su_write});
        if (su_write) check("pwdata_stable", mo_pwdata, su_wdata);
        if (pready) begin
          ap_addr  = mo_paddr;
          ap_wdata = mo_pwdata;
          ap_write = mo_pwrite;
          ap_psel  = mo_psel;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_tr(input int i, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int st, input logic rsp, input logic apb);
    tr_write[i] = w; tr_addr[i] = a; tr_data[i] = d;
    tr_stall[i] = st; tr_resp[i] = rsp; tr_apb[i] = apb;
  endtask

  task automatic drive_idle();
    hsel = 1'b0; hsel_wd = 1'b0; htrans = 2'b00;
  endtask

  task automatic drive_addr(input int i);
    if (use_wd) hsel_wd = 1'b1; else hsel = 1'b1;
    htrans = (i == 0) ? 2'b10 : 2'b11;
    haddr  = tr_addr[i];
    hwrite = tr_write[i];
    if (!tr_write[i]) exp_q.push_back(tr_data[i]);
  endtask

  task automatic complete(input int i, input int stalls);
    logic [31:0] exp;
    check("stall_cycles", stalls, tr_stall[i]);
    check("hresp", {31'b0, mo_hresp}, {31'b0, tr_resp[i]});
    if (tr_resp[i]) begin
      check("err1_hresp", {31'b0, err1_resp}, 32'd1);
      check("psel_dropped", {16'b0, mo_psel}, 32'd0);
    end
    if (!tr_write[i]) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $error("FAIL scoreboard_empty: observed empty queue expected entry");
        exp = 32'h0;
      end else exp = exp_q.pop_front();
    end
    if (!tr_write[i] && !tr_resp[i]) begin
      check("hrdata", mo_hrdata, exp);
      last_rd[use_wd] = exp;
    end else begin
      check("hrdata_hold", mo_hrdata, last_rd[use_wd]);
    end
    if (tr_apb[i]) begin
      check("apb_paddr", ap_addr, tr_addr[i]);
      check("apb_pwrite", {31'b0, ap_write}, {31'b0, tr_write[i]});
      check("apb_psel", {16'b0, ap_psel}, 32'd1 << tr_addr[i][15:12]);
      if (tr_write[i]) check("apb_pwdata", ap_wdata, tr_data[i]);
    end
  endtask

  // Pipelined AHB master.
  // Each call starts on a negedge and returns on the negedge where the
  // last data phase completes.
  task automatic run_burst(input int n);
    int ai, di, done_n, stalls, cyc;
    logic rdy;
    ai = 0; di = -1; done_n = 0; stalls = 0; cyc = 0;
    err1_resp = 1'b0;
    drive_addr(0);
    while (done_n < n) begin
      rdy = mo_hreadyout;
      if (!rdy) begin
        stalls++;
        err1_resp = mo_hresp;
      end else if (di >= 0) begin
        complete(di, stalls);
        done_n++;
      end
      if (done_n == n) break;
      if (cyc >= 200) begin
        n_vec++; n_err++;
        $error("FAIL burst_timeout: observed %0d done expected %0d", done_n, n);
        break;
      end
      @(negedge HCLK);
      cyc++;
      if (rdy) begin
        if (ai < n) begin
          di = ai; cur = di; stalls = 0;
          if (tr_write[di]) hwdata = tr_data[di];
          ai++;
          check("accept_state", {29'b0, mo_state}, tr_write[di] ? 32'd1 : 32'd2);
        end
        if (ai < n) drive_addr(ai);
        else        drive_idle();
      end
    end
    drive_idle();
  endtask

  task automatic idle(input int k);
    drive_idle();
    repeat (k) @(negedge HCLK);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [1:0] nt_trans[3];
    logic       nt_sel[3];
    HRESETn = 1'b0; hsel = 1'b0; hsel_wd = 1'b0; htrans = 2'b00; haddr = '0;
    hwrite = 1'b0; hsize = 3'b010; hwdata = '0; pslverr = 1'b0; use_wd = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
    set_tr(0, 1'b0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    repeat (2) @(negedge HCLK);

    // Reset values
    check("rst_hreadyout", {31'b0, a_hreadyout}, 32'd1);
    check("rst_hresp", {31'b0, a_hresp}, 32'd0);
    check("rst_hrdata", a_hrdata, 32'h0);
    check("rst_psel", {16'b0, a_psel}, 32'h0);
    check("rst_penable", {31'b0, a_penable}, 32'd0);
    check("rst_paddr", a_paddr, 32'h0);
    check("rst_pwdata", a_pwdata, 32'h0);
    check("rst_state", {29'b0, a_state}, 32'd0);
    HRESETn = 1'b1;
    @(negedge HCLK);

    // Single zero-wait read, then a single zero-wait write
    set_tr(0, 1'b0, 32'h4000_1008, 32'hA5A5_0001, 2, 1'b0, 1'b1);
    run_burst(1); idle(2);
    set_tr(0, 1'b1, 32'h4000_0004, 32'h0000_00FF, 3, 1'b0, 1'b1);
    run_burst(1); idle(2);

    // IDLE and BUSY transfers, and a NONSEQ with HSEL low, must not start anything
    nt_trans[0] = 2'b00; nt_trans[1] = 2'b01; nt_trans[2] = 2'b10;
    nt_sel[0] = 1'b1;    nt_sel[1] = 1'b1;    nt_sel[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      hsel = nt_sel[k]; htrans = nt_trans[k]; haddr = 32'h4000_2000; hwrite = 1'b1;
      @(negedge HCLK);
      check("noreq_state", {29'b0, a_state}, 32'd0);
      check("noreq_psel", {16'b0, a_psel}, 32'h0);
      check("noreq_hreadyout", {31'b0, a_hreadyout}, 32'd1);
    end
    idle(1);

    // Read with five PREADY-low ACCESS cycles
    wait_n = 5;
    set_tr(0, 1'b0, 32'h4000_3010, 32'h1234_5678, 7, 1'b0, 1'b1);
    run_burst(1); idle(2);
    wait_n = 0;

    // Write answered with PSLVERR.
    // A request in the ERR2 cycle must be ignored.
    pslverr = 1'b1;
    set_tr(0, 1'b1, 32'h4000_2000, 32'hCAFE_F00D, 4, 1'b1, 1'b1);
    run_burst(1);
    pslverr = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_2004; hwrite = 1'b0;
    @(negedge HCLK);
    drive_idle();
    check("err2_ignore_state", {29'b0, a_state}, 32'd0);
    check("err2_ignore_hresp", {31'b0, a_hresp}, 32'd0);
    check("err2_ignore_hreadyout", {31'b0, a_hreadyout}, 32'd1);
    idle(2);

    // Watchdog instance: PREADY stuck low, then a normal read
    use_wd = 1'b1;
    wait_n = 1000;
    set_tr(0, 1'b0, 32'h4000_5000, 32'h0BAD_0BAD, 6, 1'b1, 1'b0);
    run_burst(1); idle(2);
    wait_n = 0;
    set_tr(0, 1'b0, 32'h4000_5004, 32'h5555_AAAA, 2, 1'b0, 1'b1);
    run_burst(1); idle(2);
    use_wd = 1'b0;

    // Back-to-back read, write, read with no idle cycle
    set_tr(0, 1'b0, 32'h4000_1100, 32'h1111_0000, 2, 1'b0, 1'b1);
    set_tr(1, 1'b1, 32'h4000_7008, 32'h7777_0008, 3, 1'b0, 1'b1);
    set_tr(2, 1'b0, 32'h4000_F00C, 32'hFFFF_000C, 2, 1'b0, 1'b1);
    run_burst(3); idle(2);

    // Reset asserted in the middle of ACCESS
    wait_n = 1000;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h4000_4000; hwrite = 1'b0;
    @(negedge HCLK);
    drive_idle();
    @(negedge HCLK);
    check("mid_access_penable", {31'b0, a_penable}, 32'd1);
    HRESETn = 1'b0;
    #1;
    check("arst_psel", {16'b0, a_psel}, 32'h0);
    check("arst_penable", {31'b0, a_penable}, 32'd0);
    check("arst_hreadyout", {31'b0, a_hreadyout}, 32'd1);
    check("arst_hresp", {31'b0, a_hresp}, 32'd0);
    check("arst_hrdata", a_hrdata, 32'h0);
    check("arst_paddr", a_paddr, 32'h0);
    check("arst_pwdata", a_pwdata, 32'h0);
    check("arst_state", {29'b0, a_state}, 32'd0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    wait_n = 0;
    last_rd[0] = '0;
    @(negedge HCLK);

    // Recovery after reset
    set_tr(0, 1'b0, 32'h4000_6000, 32'h6060_6060, 2, 1'b0, 1'b1);
    run_burst(1); idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Overall time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
